mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register.
//  - Drives a data-memory request/ready handshake from the registered EX/MEM fields.
//  - Resolves branches: PCSrc = Branch & zero.
//  - Selects the write-back value and registers the MEM/WB fields.
//  - Raises mem_stall while a memory access is outstanding, so upstream registers hold.
// PARAMETERS
//  DW        32  data/address width
//  MAX_WAIT  15  cycles in WAIT without dmem_ready before abort (only with DMEM_TIMEOUT_EN)
// PORTS
//  clk               in   1   clock, rising edge
//  reset             in   1   async, active-low
//  ALUOut_in         in   DW  effective address / ALU result
//  DataBusB_in       in   DW  store data
//  PC_add_4_in       in   DW  PC+4 (jal link value)
//  Branch_addr_in    in   DW  branch target
//  RegWriteAddr_in   in   5   destination register
//  MemToReg_in       in   2   WB select: 00 ALU, 01 mem, 10 PC+4, 11 ALU
//  MemRead_in        in   1   load
//  MemWrite_in       in   1   store
//  RegWrite_in       in   1   register write enable
//  Branch_in         in   1   branch instruction
//  alu_zero_in       in   1   ALU zero flag
//  dmem_req          out  1   memory request (combinational)
//  dmem_we           out  1   1 = write
//  dmem_addr         out  DW  = ALUOut_in
//  dmem_wdata        out  DW  = DataBusB_in
//  dmem_rdata        in   DW  read data, valid when dmem_ready = 1
//  dmem_ready        in   1   access complete this cycle
//  PCSrc             out  1   take branch (combinational)
//  Branch_target     out  DW  = Branch_addr_in
//  mem_stall         out  1   hold PC, IF/ID, ID/EX and EX/MEM
//  mem_err           out  1   registered 1-cycle pulse: misaligned access or timeout
//  WB_data_out       out  DW  MEM/WB write-back data
//  RegWriteAddr_out  out  5   MEM/WB destination register
//  RegWrite_out      out  1   MEM/WB write enable
// BEHAVIOUR
//  - Reset (reset = 0, async):
//      state = IDLE; wait counter = 0.
//      WB_data_out, RegWriteAddr_out, RegWrite_out and mem_err clear to 0 immediately.
//      dmem_req is forced to 0 immediately, including mid-access; the pending access is dropped.
//  - FSM states IDLE and WAIT. An access is requested when (MemRead_in | MemWrite_in) and ALUOut_in[1:0] = 00.
//  - dmem_req is 1 when an access is requested in IDLE, and for every cycle in WAIT.
//  - dmem_we = MemWrite_in. If MemRead_in and MemWrite_in are both 1, the write wins and the read data is ignored.
//  - IDLE -> WAIT when a request is made and dmem_ready = 0; stay in IDLE on same-cycle ready (0-wait access).
//  - WAIT -> IDLE when dmem_ready = 1.
//  - mem_stall = dmem_req & ~dmem_ready.
//  - MEM/WB register loads on every edge:
//      if mem_stall = 1: bubble (RegWrite_out = 0, other MEM/WB fields hold).
//      else: RegWriteAddr_out <= RegWriteAddr_in; RegWrite_out <= RegWrite_in;
//            WB_data_out <= value selected by MemToReg_in.
//  - Latency: 1 cycle for non-memory ops; (wait cycles + 1) for loads and stores.
//  - Misaligned access (ALUOut_in[1:0] != 00 with MemRead_in or MemWrite_in):
//      no dmem_req; mem_err = 1 for the next cycle; RegWrite_out = 0 for that instruction; no stall.
//  - PCSrc = Branch_in & alu_zero_in & ~mem_stall. Branch instructions never request memory.
// CONFIGURATION
//  DMEM_TIMEOUT_EN defined:
//    - A counter increments each cycle in WAIT.
//    - When the count reaches MAX_WAIT without dmem_ready: return to IDLE, drop dmem_req,
//      pulse mem_err for 1 cycle, insert a bubble, release mem_stall. A late dmem_ready is ignored.
//  DMEM_TIMEOUT_EN undefined: no counter; WAIT lasts until dmem_ready; mem_err flags misalignment only.
// TESTING
//  1. lw, ALUOut_in = 0x10, dmem_ready after 3 cycles with rdata = 0xDEADBEEF
//     -> mem_stall = 1 for 3 cycles; next edge WB_data_out = 0xDEADBEEF, RegWrite_out = 1.
//  2. sw, ALUOut_in = 0x20, DataBusB_in = 0x12345678, dmem_ready same cycle
//     -> dmem_req = dmem_we = 1, wdata = 0x12345678, mem_stall = 0, RegWrite_out = 0.
//  3. Branch_in = 1, alu_zero_in = 1, Branch_addr_in = 0x40
//     -> PCSrc = 1 and Branch_target = 0x40 in the same cycle. With alu_zero_in = 0 -> PCSrc = 0.
//  4. jal with MemToReg_in = 10, PC_add_4_in = 0x104, RegWriteAddr_in = 31
//     -> WB_data_out = 0x104, RegWriteAddr_out = 31.
//  5. lw, ALUOut_in = 0x13
//     -> dmem_req = 0, mem_err = 1 for one cycle, RegWrite_out = 0.
//  6. reset = 0 mid-WAIT -> dmem_req and all registered outputs 0 with no clock edge.
//     With DMEM_TIMEOUT_EN and MAX_WAIT = 4, no ready -> abort after 4 cycles, mem_err pulse, mem_stall drops.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory handshake, branch resolve, MEM/WB register.
// Optional DMEM_TIMEOUT_EN aborts an access after MAX_WAIT cycles without dmem_ready.
module mem_access_stage #(
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] ALUOut_in,
  input  logic [DW-1:0] DataBusB_in,
  input  logic [DW-1:0] PC_add_4_in,
  input  logic [DW-1:0] Branch_addr_in,
  input  logic [4:0]    RegWriteAddr_in,
  input  logic [1:0]    MemToReg_in,
  input  logic          MemRead_in,
  input  logic          MemWrite_in,
  input  logic          RegWrite_in,
  input  logic          Branch_in,
  input  logic          alu_zero_in,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ready,
  output logic          PCSrc,
  output logic [DW-1:0] Branch_target,
  output logic          mem_stall,
  output logic          mem_err,
  output logic [DW-1:0] WB_data_out,
  output logic [4:0]    RegWriteAddr_out,
  output logic          RegWrite_out
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e        state_q, state_d;
  logic          mem_op, aligned, access_req, misaligned, timeout, req_raw;
  logic          err_d, mem_err_q;
  logic [DW-1:0] wb_data_d, wb_data_q;
  logic [4:0]    rd_addr_q;
  logic          reg_write_q;

  assign mem_op     = MemRead_in | MemWrite_in;
  assign aligned    = (ALUOut_in[1:0] == 2'b00);
  assign access_req = mem_op & aligned;
  assign misaligned = mem_op & ~aligned;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Abort on the MAX_WAIT-th waiting cycle; a ready arriving after that is ignored.
  assign timeout = (state_q == StWait) & ~dmem_ready & (cnt_q == CntW'(MAX_WAIT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == StWait && !dmem_ready && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_raw = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access_req) begin
          req_raw = 1'b1;
          if (!dmem_ready) begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (timeout) begin
          state_d = StIdle;
        end else begin
          req_raw = 1'b1;
          if (dmem_ready) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Gated by reset so an in-flight request drops the instant reset asserts.
  assign dmem_req      = req_raw & reset;
  assign dmem_we       = MemWrite_in;
  assign dmem_addr     = ALUOut_in;
  assign dmem_wdata    = DataBusB_in;
  assign mem_stall     = dmem_req & ~dmem_ready;
  assign PCSrc         = Branch_in & alu_zero_in & ~mem_stall;
  assign Branch_target = Branch_addr_in;

  // A store wins over a simultaneous load, so the read data is never selected then.
  always_comb begin
    wb_data_d = ALUOut_in;
    case (MemToReg_in)
      2'b01:   wb_data_d = (MemRead_in & ~MemWrite_in) ? dmem_rdata : ALUOut_in;
      2'b10:   wb_data_d = PC_add_4_in;
      default: wb_data_d = ALUOut_in;
    endcase
  end

  assign err_d = ((state_q == StIdle) & misaligned) | timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      mem_err_q   <= 1'b0;
      wb_data_q   <= '0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= err_d;
      if (mem_stall) begin
        reg_write_q <= 1'b0;
      end else begin
        wb_data_q   <= wb_data_d;
        rd_addr_q   <= RegWriteAddr_in;
        reg_write_q <= RegWrite_in & ~err_d;
      end
    end
  end

  assign mem_err          = mem_err_q;
  assign WB_data_out      = wb_data_q;
  assign RegWriteAddr_out = rd_addr_q;
  assign RegWrite_out     = reg_write_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage plus stall, reset and timeout sequences.
// The timeout sequence is built only when DMEM_TIMEOUT_EN is defined (MAX_WAIT = 4 here).
module tb_mem_access_stage;

  logic        clk, rst_n;
  logic [31:0] alu, wd, pc4, ba, rdata;
  logic [4:0]  rd;
  logic [1:0]  m2r;
  logic        mr, mw, rw, br, zero, rdy;
  logic        req, we, pcsrc, stall, err, rw_out;
  logic [31:0] addr, wdata, target, wb;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(rst_n),
    .ALUOut_in(alu), .DataBusB_in(wd), .PC_add_4_in(pc4), .Branch_addr_in(ba),
    .RegWriteAddr_in(rd), .MemToReg_in(m2r), .MemRead_in(mr), .MemWrite_in(mw),
    .RegWrite_in(rw), .Branch_in(br), .alu_zero_in(zero),
    .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_wdata(wdata),
    .dmem_rdata(rdata), .dmem_ready(rdy),
    .PCSrc(pcsrc), .Branch_target(target), .mem_stall(stall), .mem_err(err),
    .WB_data_out(wb), .RegWriteAddr_out(rd_out), .RegWrite_out(rw_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] alu, wd, pc4, ba;
    logic [4:0]  rd;
    logic [1:0]  m2r;
    logic        mr, mw, rw, br, z;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req, e_we, e_pcsrc, e_stall;
    logic [31:0] e_wb;
    logic [4:0]  e_rd;
    logic        e_rw, e_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nop();
    alu = '0; wd = '0; pc4 = '0; ba = '0; rd = '0; m2r = 2'b00;
    mr = 0; mw = 0; rw = 0; br = 0; zero = 0; rdata = '0; rdy = 0;
  endtask

  task automatic set_lw(input logic [31:0] a, input logic [4:0] r);
    nop();
    alu = a; rd = r; m2r = 2'b01; mr = 1; rw = 1;
  endtask

  initial begin
    //            alu          wd           pc4     ba     rd  m2r  mr mw rw br z  rdata         rdy
    //            req we pcs stl wb           rd  rw err
    vecs[0] = '{32'h20, 32'h12345678, 32'h24, 32'h0, 5'd0, 2'b00, 0, 1, 0, 0, 0, 32'h0, 1,
                1, 1, 0, 0, 32'h20, 5'd0, 0, 0};
    vecs[1] = '{32'h0, 32'h0, 32'h8, 32'h40, 5'd0, 2'b00, 0, 0, 0, 1, 1, 32'h0, 0,
                0, 0, 1, 0, 32'h0, 5'd0, 0, 0};
    vecs[2] = '{32'h4, 32'h0, 32'h8, 32'h40, 5'd0, 2'b00, 0, 0, 0, 1, 0, 32'h0, 0,
                0, 0, 0, 0, 32'h4, 5'd0, 0, 0};
    vecs[3] = '{32'h99, 32'h0, 32'h104, 32'h0, 5'd31, 2'b10, 0, 0, 1, 0, 0, 32'h0, 0,
                0, 0, 0, 0, 32'h104, 5'd31, 1, 0};
    vecs[4] = '{32'h13, 32'h0, 32'h0, 32'h0, 5'd8, 2'b01, 1, 0, 1, 0, 0, 32'h0, 0,
                0, 0, 0, 0, 32'h0, 5'd8, 0, 1};
    vecs[5] = '{32'h55AA, 32'h0, 32'h0, 32'h0, 5'd7, 2'b00, 0, 0, 1, 0, 0, 32'h0, 0,
                0, 0, 0, 0, 32'h55AA, 5'd7, 1, 0};
    vecs[6] = '{32'h30, 32'h0, 32'h0, 32'h0, 5'd9, 2'b01, 1, 0, 1, 0, 0, 32'hCAFEF00D, 1,
                1, 0, 0, 0, 32'hCAFEF00D, 5'd9, 1, 0};
    vecs[7] = '{32'h77, 32'h0, 32'h0, 32'h0, 5'd3, 2'b11, 0, 0, 1, 0, 0, 32'hFFFF, 0,
                0, 0, 0, 0, 32'h77, 5'd3, 1, 0};
    vecs[8] = '{32'h44, 32'hAB, 32'h0, 32'h0, 5'd4, 2'b01, 1, 1, 1, 0, 0, 32'hBAD, 1,
                1, 1, 0, 0, 32'h44, 5'd4, 1, 0};
    vecs[9] = '{32'h22, 32'h1, 32'h0, 32'h0, 5'd2, 2'b00, 0, 1, 0, 0, 0, 32'h0, 0,
                0, 1, 0, 0, 32'h22, 5'd2, 0, 1};

    // Reset held with an aligned load presented: request must stay low.
    rst_n = 0;
    set_lw(32'h10, 5'd5);
    #1;
    check("reset_req", req, 0);
    check("reset_wb", wb, 0);
    check("reset_rd", rd_out, 0);
    check("reset_rw", rw_out, 0);
    check("reset_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    nop();

    foreach (vecs[i]) begin
      @(negedge clk);
      alu = vecs[i].alu; wd = vecs[i].wd; pc4 = vecs[i].pc4; ba = vecs[i].ba;
      rd = vecs[i].rd; m2r = vecs[i].m2r; mr = vecs[i].mr; mw = vecs[i].mw;
      rw = vecs[i].rw; br = vecs[i].br; zero = vecs[i].z; rdata = vecs[i].rdata;
      rdy = vecs[i].rdy;
      #1;
      check($sformatf("v%0d_req", i), req, vecs[i].e_req);
      check($sformatf("v%0d_we", i), we, vecs[i].e_we);
      check($sformatf("v%0d_addr", i), addr, vecs[i].alu);
      check($sformatf("v%0d_wdata", i), wdata, vecs[i].wd);
      check($sformatf("v%0d_pcsrc", i), pcsrc, vecs[i].e_pcsrc);
      check($sformatf("v%0d_target", i), target, vecs[i].ba);
      check($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wb", i), wb, vecs[i].e_wb);
      check($sformatf("v%0d_rd", i), rd_out, vecs[i].e_rd);
      check($sformatf("v%0d_rw", i), rw_out, vecs[i].e_rw);
      check($sformatf("v%0d_err", i), err, vecs[i].e_err);
    end

    // Load with three wait cycles, then ready with data.
    @(negedge clk);
    set_lw(32'h10, 5'd5);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("lw_wait%0d_stall", c), stall, 1);
      check($sformatf("lw_wait%0d_req", c), req, 1);
      @(posedge clk);
      #1;
      check($sformatf("lw_wait%0d_bubble", c), rw_out, 0);
      @(negedge clk);
    end
    rdy = 1; rdata = 32'hDEADBEEF;
    #1;
    check("lw_ready_stall", stall, 0);
    check("lw_ready_req", req, 1);
    @(posedge clk);
    #1;
    check("lw_ready_wb", wb, 32'hDEADBEEF);
    check("lw_ready_rw", rw_out, 1);
    check("lw_ready_rd", rd_out, 5);
    @(negedge clk);
    nop();
    #1;
    check("lw_after_req", req, 0);

    // Async reset in the middle of a waiting access.
    @(negedge clk);
    nop();
    alu = 32'h99; pc4 = 32'h104; rd = 5'd31; m2r = 2'b10; rw = 1;
    @(negedge clk);
    set_lw(32'h10, 5'd6);
    @(negedge clk);
    #1;
    check("midrst_pre_stall", stall, 1);
    check("midrst_pre_wb", wb, 32'h104);
    check("midrst_pre_rd", rd_out, 31);
    #2;
    rst_n = 0;
    #1;
    check("midrst_req", req, 0);
    check("midrst_stall", stall, 0);
    check("midrst_wb", wb, 0);
    check("midrst_rd", rd_out, 0);
    check("midrst_rw", rw_out, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    nop();
    @(posedge clk);
    #1;
    check("postrst_req", req, 0);

`ifdef DMEM_TIMEOUT_EN
    // No ready at all: four stalled cycles, then abort with an error pulse.
    @(negedge clk);
    set_lw(32'h50, 5'd10);
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("to_wait%0d_stall", c), stall, 1);
      @(negedge clk);
    end
    #1;
    check("to_abort_req", req, 0);
    check("to_abort_stall", stall, 0);
    @(posedge clk);
    #1;
    check("to_abort_err", err, 1);
    check("to_abort_rw", rw_out, 0);
    @(negedge clk);
    nop();
    rdy = 1;
    #1;
    check("to_late_req", req, 0);
    @(posedge clk);
    #1;
    check("to_err_clear", err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
